// File: rtl/deadlock_block_detector_pkg.sv
// Shared types and helpers for the deadlock block detector.
//   det_state_e : detector FSM states
//   sat_inc     : saturating increment for counters up to 64 bits wide
// Optional macro DEADLOCK_DETECTOR_RELEASE_EN is consumed by the top module.
package deadlock_detector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WATCH,
    BLOCKED
  } det_state_e;

  // Returns v+1, or v unchanged once it has reached max.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
    return (v == max) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/deadlock_block_detector_if.sv
// Kernel monitor <-> deadlock detector connection.
//   enable, clear               : detector controls
//   axis_block_sigs             : per-AXIS-port blocked flags
//   inst_idle_sigs              : per-instance idle flags
//   inst_block_sigs             : per-instance blocked flags
//   block, block_pulse          : deadlock status and entry strobe
//   block_src_axis/inst, block_cycle : snapshot taken at declaration
// Modports: master = monitor side (drives inputs), slave = detector side.
interface deadlock_block_detector_if #(
  parameter int unsigned N_AXIS = 1,
  parameter int unsigned N_INST = 2,
  parameter int unsigned N_BLK  = 1,
  parameter int unsigned CNT_W  = 32
);
  logic              enable;
  logic              clear;
  logic [N_AXIS-1:0] axis_block_sigs;
  logic [N_INST-1:0] inst_idle_sigs;
  logic [N_BLK-1:0]  inst_block_sigs;
  logic              block;
  logic              block_pulse;
  logic [N_AXIS-1:0] block_src_axis;
  logic [N_BLK-1:0]  block_src_inst;
  logic [CNT_W-1:0]  block_cycle;

  modport master (
    output enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    input  block, block_pulse, block_src_axis, block_src_inst, block_cycle
  );

  modport slave (
    input  enable, clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    output block, block_pulse, block_src_axis, block_src_inst, block_cycle
  );
endinterface

// File: rtl/deadlock_block_detector_persist.sv
// Persistence counter for the deadlock detector.
// Holds the stalled-sample count and the previous block vector.
//   clk, rst   : clock, synchronous active-high reset
//   vec        : current block vector {axis, inst}
//   cnt_zero   : clear the count (highest priority)
//   cnt_arm    : load the count with 1 (first stalled sample / restart)
//   cnt_step   : increment the count
//   changed    : vec differs from the vector registered last cycle
//   terminal   : count has reached PERSIST_CYCLES-1
module deadlock_persist_counter #(
  parameter int unsigned VEC_W          = 2,
  parameter int unsigned PERSIST_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VEC_W-1:0] vec,
  input  logic             cnt_zero,
  input  logic             cnt_arm,
  input  logic             cnt_step,
  output logic             changed,
  output logic             terminal
);
  // Count never exceeds PERSIST_CYCLES-1, so clog2 bits suffice (P >= 2).
  localparam int unsigned CW = (PERSIST_CYCLES > 2) ? $clog2(PERSIST_CYCLES) : 1;

  logic [CW-1:0]    cnt;
  logic [VEC_W-1:0] prev_vec;

  assign changed  = (vec != prev_vec);
  assign terminal = (cnt == CW'(PERSIST_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      prev_vec <= '0;
    end else begin
      prev_vec <= vec;
      if (cnt_zero)      cnt <= '0;
      else if (cnt_arm)  cnt <= CW'(1);
      else if (cnt_step) cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/deadlock_block_detector.sv
// Deadlock block detector: declares a kernel deadlock once a stall with an
// unchanging block vector persists for PERSIST_CYCLES consecutive samples.
// Ports:
//   kernel_monitor_clock : clock (rising edge)
//   kernel_monitor_reset : synchronous active-high reset
//   mon (slave modport)  : enable/clear, block/idle vectors in;
//                          block, block_pulse and the declaration snapshot out
// Optional: define DEADLOCK_DETECTOR_RELEASE_EN to leave BLOCKED automatically
// when the stall disappears; otherwise only clear or reset leave BLOCKED.
module deadlock_block_detector
  import deadlock_detector_pkg::*;
#(
  parameter int unsigned N_AXIS         = 1,
  parameter int unsigned N_INST         = 2,
  parameter int unsigned N_BLK          = 1,
  parameter int unsigned PERSIST_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input logic                     kernel_monitor_clock,
  input logic                     kernel_monitor_reset,
  deadlock_block_detector_if.slave mon
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  det_state_e state, state_n;

  logic                    stall;
  logic [N_AXIS+N_BLK-1:0] vec;
  logic                    changed, terminal;
  logic                    cnt_zero, cnt_arm, cnt_step;
  logic                    pulse_n, capture;

  logic [CNT_W-1:0]  cycle_cnt;
  logic              block_pulse_r;
  logic [N_AXIS-1:0] src_axis_r;
  logic [N_BLK-1:0]  src_inst_r;
  logic [CNT_W-1:0]  block_cycle_r;

  assign stall = (|mon.axis_block_sigs | |mon.inst_block_sigs) & ~(&mon.inst_idle_sigs);
  assign vec   = {mon.axis_block_sigs, mon.inst_block_sigs};

  deadlock_persist_counter #(
    .VEC_W          (N_AXIS + N_BLK),
    .PERSIST_CYCLES (PERSIST_CYCLES)
  ) u_persist (
    .clk      (kernel_monitor_clock),
    .rst      (kernel_monitor_reset),
    .vec      (vec),
    .cnt_zero (cnt_zero),
    .cnt_arm  (cnt_arm),
    .cnt_step (cnt_step),
    .changed  (changed),
    .terminal (terminal)
  );

  always_comb begin
    state_n  = state;
    pulse_n  = 1'b0;
    capture  = 1'b0;
    cnt_zero = 1'b0;
    cnt_arm  = 1'b0;
    cnt_step = 1'b0;
    if (mon.clear) begin
      // clear outranks every transition, including the terminal edge
      state_n  = IDLE;
      cnt_zero = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (mon.enable && stall) begin
            state_n = WATCH;
            cnt_arm = 1'b1;
          end else begin
            cnt_zero = 1'b1;
          end
        end
        WATCH: begin
          if (!(mon.enable && stall)) begin
            state_n  = IDLE;
            cnt_zero = 1'b1;
          end else if (changed) begin
            cnt_arm = 1'b1;
          end else if (terminal) begin
            state_n  = BLOCKED;
            pulse_n  = 1'b1;
            capture  = 1'b1;
            cnt_zero = 1'b1;
          end else begin
            cnt_step = 1'b1;
          end
        end
        BLOCKED: begin
          cnt_zero = 1'b1;
`ifdef DEADLOCK_DETECTOR_RELEASE_EN
          if (!stall) state_n = IDLE;
`endif
        end
        default: begin
          state_n  = IDLE;
          cnt_zero = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge kernel_monitor_clock) begin
    if (kernel_monitor_reset) begin
      state         <= IDLE;
      cycle_cnt     <= '0;
      block_pulse_r <= 1'b0;
      src_axis_r    <= '0;
      src_inst_r    <= '0;
      block_cycle_r <= '0;
    end else begin
      state         <= state_n;
      cycle_cnt     <= CNT_W'(sat_inc(64'(cycle_cnt), 64'(CNT_MAX)));
      block_pulse_r <= pulse_n;
      if (capture) begin
        src_axis_r    <= mon.axis_block_sigs;
        src_inst_r    <= mon.inst_block_sigs;
        block_cycle_r <= cycle_cnt;
      end
    end
  end

  assign mon.block          = (state == BLOCKED);
  assign mon.block_pulse    = block_pulse_r;
  assign mon.block_src_axis = src_axis_r;
  assign mon.block_src_inst = src_inst_r;
  assign mon.block_cycle    = block_cycle_r;
endmodule

// File: tb/tb_deadlock_block_detector.sv
module tb_deadlock_block_detector;
  localparam int unsigned P  = 4;
  localparam int unsigned NA = 1;
  localparam int unsigned NI = 2;
  localparam int unsigned NB = 1;
  localparam int unsigned CW = 6;
  localparam int unsigned CYC_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  deadlock_block_detector_if #(.N_AXIS(NA), .N_INST(NI), .N_BLK(NB), .CNT_W(CW)) mon_if ();

  deadlock_block_detector #(
    .N_AXIS(NA), .N_INST(NI), .N_BLK(NB), .PERSIST_CYCLES(P), .CNT_W(CW)
  ) dut (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst),
    .mon                  (mon_if)
  );

  typedef struct packed {
    logic          block;
    logic          pulse;
    logic [NA-1:0] sa;
    logic [NB-1:0] si;
    logic [CW-1:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counts consecutive enabled stalled samples that carry the
  // same block vector as the previous sample; the P-th such sample declares.
  int unsigned    m_run;
  bit             m_blocked;
  logic [NA+NB-1:0] m_last_vec;
  int unsigned    m_cyc;
  exp_t           m_out;

  task automatic model_update(input bit r, input bit en, input bit clr,
                              input logic [NA-1:0] ax, input logic [NI-1:0] id,
                              input logic [NB-1:0] bl);
    logic [NA+NB-1:0] v;
    bit st;
    v  = {ax, bl};
    st = ((ax != '0) || (bl != '0)) && (id != '1);
    if (r) begin
      m_run = 0; m_blocked = 0; m_last_vec = '0; m_cyc = 0; m_out = '0;
      return;
    end
    m_out.pulse = 1'b0;
    if (clr) begin
      m_blocked = 0;
      m_run     = 0;
    end else if (m_blocked) begin
`ifdef DEADLOCK_DETECTOR_RELEASE_EN
      if (!st) m_blocked = 0;
`endif
      m_run = 0;
    end else if (en && st) begin
      m_run = (m_run > 0 && v == m_last_vec) ? m_run + 1 : 1;
      if (m_run == P) begin
        m_blocked   = 1;
        m_out.pulse = 1'b1;
        m_out.sa    = ax;
        m_out.si    = bl;
        m_out.bc    = CW'(m_cyc);
        m_run       = 0;
      end
    end else begin
      m_run = 0;
    end
    m_out.block = m_blocked;
    m_last_vec  = v;
    if (m_cyc < CYC_MAX) m_cyc = m_cyc + 1;
  endtask

  task automatic drive_cycle(input bit r, input bit en, input bit clr,
                             input logic [NA-1:0] ax, input logic [NI-1:0] id,
                             input logic [NB-1:0] bl);
    @(negedge clk);
    rst                    = r;
    mon_if.enable          = en;
    mon_if.clear           = clr;
    mon_if.axis_block_sigs = ax;
    mon_if.inst_idle_sigs  = id;
    mon_if.inst_block_sigs = bl;
    model_update(r, en, clr, ax, id, bl);
    exp_q.push_back(m_out);
  endtask

  // Monitor: one expected record per clock edge, compared 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (mon_if.block !== e.block) begin
          errors++;
          $display("FAIL block t=%0t got %b want %b", $time, mon_if.block, e.block);
        end
        checks++;
        if (mon_if.block_pulse !== e.pulse) begin
          errors++;
          $display("FAIL block_pulse t=%0t got %b want %b", $time, mon_if.block_pulse, e.pulse);
        end
        checks++;
        if ({mon_if.block_src_axis, mon_if.block_src_inst, mon_if.block_cycle} !== {e.sa, e.si, e.bc}) begin
          errors++;
          $display("FAIL snapshot t=%0t got axis=%b inst=%b cycle=%0d want axis=%b inst=%b cycle=%0d",
                   $time, mon_if.block_src_axis, mon_if.block_src_inst, mon_if.block_cycle,
                   e.sa, e.si, e.bc);
        end
      end
    end
  end

  initial begin
    logic [NA-1:0] ax;
    logic [NI-1:0] id;
    logic [NB-1:0] bl;
    bit en, clr;
    mon_if.enable = 1'b0; mon_if.clear = 1'b0;
    mon_if.axis_block_sigs = '0; mon_if.inst_idle_sigs = '0; mon_if.inst_block_sigs = '0;
    m_run = 0; m_blocked = 0; m_last_vec = '0; m_cyc = 0; m_out = '0;

    // reset
    repeat (2) drive_cycle(1, 0, 0, '0, '0, '0);
    // constant stall: declares on the 4th sample, snapshot cycle 3
    repeat (6) drive_cycle(0, 1, 0, 1'b1, 2'b00, 1'b0);
    // stall removed: sticky (or released when the macro is defined)
    repeat (2) drive_cycle(0, 1, 0, 1'b0, 2'b00, 1'b0);
    drive_cycle(0, 1, 1, 1'b0, 2'b00, 1'b0);
    drive_cycle(0, 1, 0, 1'b0, 2'b00, 1'b0);
    // progress restart: inst_block toggles on the third sample
    repeat (2) drive_cycle(0, 1, 0, 1'b1, 2'b00, 1'b0);
    repeat (6) drive_cycle(0, 1, 0, 1'b1, 2'b00, 1'b1);
    drive_cycle(0, 1, 1, 1'b0, 2'b00, 1'b0);
    // 3 stalled, 1 clear, then 5 stalled
    repeat (3) drive_cycle(0, 1, 0, 1'b1, 2'b01, 1'b0);
    drive_cycle(0, 1, 0, 1'b0, 2'b01, 1'b0);
    repeat (5) drive_cycle(0, 1, 0, 1'b1, 2'b01, 1'b0);
    drive_cycle(0, 1, 1, 1'b0, 2'b00, 1'b0);
    // all instances idle: never a stall
    repeat (10) drive_cycle(0, 1, 0, 1'b1, 2'b11, 1'b1);
    // clear on the terminal edge
    drive_cycle(0, 1, 0, 1'b0, 2'b00, 1'b0);
    repeat (3) drive_cycle(0, 1, 0, 1'b1, 2'b10, 1'b1);
    drive_cycle(0, 1, 1, 1'b1, 2'b10, 1'b1);
    repeat (2) drive_cycle(0, 1, 0, 1'b1, 2'b10, 1'b1);
    // reset while watching
    drive_cycle(1, 1, 0, 1'b1, 2'b10, 1'b1);
    drive_cycle(0, 1, 0, 1'b0, 2'b00, 1'b0);
    // randomized traffic; long enough for the cycle counter to saturate
    ax = 1'b1; bl = 1'b0; id = 2'b00;
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) ax = NA'($urandom);
      if ($urandom_range(0, 7) == 0) bl = NB'($urandom);
      id = ($urandom_range(0, 9) == 0) ? '1 : NI'($urandom_range(0, 2));
      drive_cycle(0, en, clr, ax, id, bl);
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
